mem_bus_load_checker: RTL and testbench

- Memory-bus initiator that drives the same word-addressed req/gnt/addr/wdata/strb/we/rdata interface the SoC data and instruction memories respond on.
- Used in tiny-SoC benches and boot flows for two jobs:
  - Load an image streamed in over a valid/ready port into a memory.
  - Read the image back and compare a running checksum of the written words against one of the read words.
- Sits beside, and is muxed with, the core's memory port in front of the SRAM/ROM responders.

---
 rtl/mem_bus_load_checker.sv | 141 ++++++++++++++
 tb/tb_mem_bus_load_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_load_checker.sv
// Memory-bus initiator that streams an image into a word-addressed memory,
// reads it back and flags a mismatch between write and read checksums.
module mem_bus_load_checker #(
    parameter int AddrWidth = 15,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [CntWidth-1:0]  num_words_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [31:0]          wr_data_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [31:0]          mem_strb_o,
    output logic                 mem_we_o,
    input  logic [31:0]          mem_rdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [31:0]          checksum_o
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [AddrWidth-1:0] AddrOne = 1;
    localparam logic [CntWidth-1:0]  CntOne  = 1;

    state_t               state, state_next;
    logic [AddrWidth-1:0] base, addr;
    logic [CntWidth-1:0]  num, cnt;
    logic [31:0]          wsum, rsum;
    logic                 rvalid, err;
    logic                 wr_fire, rd_fire, last;

    function automatic logic [31:0] csum_step(input logic [31:0] c, input logic [31:0] w);
        return {c[30:0], c[31]} ^ w;
    endfunction

    assign wr_fire = (state == WRITE) && wr_valid_i && mem_gnt_i;
    assign rd_fire = (state == READ) && mem_gnt_i;
    // num is never zero outside IDLE, so num-1 is the index of the final word
    assign last    = (cnt == num - CntOne);

    always_comb begin
        state_next  = state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_strb_o  = '0;
        mem_wdata_o = '0;
        wr_ready_o  = 1'b0;
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = (num_words_i == '0) ? DONE : WRITE;
            end
            WRITE: begin
                mem_req_o   = wr_valid_i;
                mem_we_o    = 1'b1;
                mem_strb_o  = '1;
                mem_wdata_o = wr_data_i;
                wr_ready_o  = mem_gnt_i;
                if (wr_fire && last) state_next = READ;
            end
            READ: begin
                mem_req_o = 1'b1;
                if (rd_fire && last) state_next = DRAIN;
            end
            DRAIN: state_next = DONE;
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr_o = addr;
    assign busy_o     = (state != IDLE);
    assign checksum_o = wsum;
    // The mismatch is already visible during the done pulse, then held by err
    assign error_o    = err | ((state == DONE) && (wsum != rsum));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            base   <= '0;
            addr   <= '0;
            num    <= '0;
            cnt    <= '0;
            wsum   <= '0;
            rsum   <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            rvalid <= rd_fire;
            if (rvalid) rsum <= csum_step(rsum, mem_rdata_i);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        base <= base_addr_i;
                        addr <= base_addr_i;
                        num  <= num_words_i;
                        cnt  <= '0;
                        wsum <= '0;
                        rsum <= '0;
                        err  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        wsum <= csum_step(wsum, wr_data_i);
                        if (last) begin
                            addr <= base;
                            cnt  <= '0;
                        end else begin
                            addr <= addr + AddrOne;
                            cnt  <= cnt + CntOne;
                        end
                    end
                end
                READ: begin
                    if (rd_fire) begin
                        addr <= addr + AddrOne;
                        cnt  <= cnt + CntOne;
                    end
                end
                DONE: begin
                    if (wsum != rsum) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_load_checker.sv
// Directed bench for mem_bus_load_checker with an SRAM responder that can
// corrupt one address on read.
`timescale 1ns/1ps
module tb_mem_bus_load_checker;

    localparam int AW = 15;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, wr_valid, wr_ready, mem_req, mem_gnt, mem_we;
    logic          busy, done, error;
    logic [AW-1:0] base_addr, mem_addr;
    logic [CW-1:0] num_words;
    logic [31:0]   wr_data, mem_wdata, mem_strb, mem_rdata, checksum;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]   sram [0:32767];
    logic          flip_en = 1'b0;
    logic [AW-1:0] waddr_log[$];
    logic [AW-1:0] raddr_log[$];
    logic [31:0]   wdata_log[$];
    logic [31:0]   stream[$];

    int   done_cyc, early_rd, req_seen;
    logic err_at_done, err_cyc1, ready_at_start;

    always #5 clk = ~clk;

    mem_bus_load_checker #(.AddrWidth(AW), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
        .num_words_i(num_words), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_data_i(wr_data), .mem_req_o(mem_req), .mem_gnt_i(mem_gnt),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
        .mem_we_o(mem_we), .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done),
        .error_o(error), .checksum_o(checksum)
    );

    // Responder: read data appears the cycle after a granted read
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                sram[mem_addr] <= (sram[mem_addr] & ~mem_strb) | (mem_wdata & mem_strb);
                waddr_log.push_back(mem_addr);
                wdata_log.push_back(mem_wdata);
            end else begin
                mem_rdata <= sram[mem_addr] ^
                    ((flip_en && mem_addr == 15'h0012) ? 32'h1 : 32'h0);
                raddr_log.push_back(mem_addr);
            end
        end
    end

    function automatic logic [31:0] csum(input logic [31:0] c, input logic [31:0] w);
        return {c[30:0], c[31]} ^ w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives one job and returns at the falling edge
    // after done (or at cycle abort_at, sampled, still inside the job).
    task automatic run_job(input logic [AW-1:0] b, input int n, input bit rnd, input int abort_at);
        int idx;
        int cyc;
        idx = 0;
        done_cyc = -1; early_rd = 0; req_seen = 0; err_at_done = 1'b0;
        waddr_log.delete(); raddr_log.delete(); wdata_log.delete();
        start = 1'b1; base_addr = b; num_words = CW'(n);
        wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; mem_gnt = 1'b1;
        #1;
        ready_at_start = wr_ready;
        if (mem_req) req_seen++;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 4000 && done_cyc < 0) begin
            mem_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < n) begin
                wr_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                wr_data  = stream[idx];
            end else begin
                wr_valid = 1'b0;
                wr_data  = '0;
            end
            #1;
            if (cyc == abort_at) return;
            if (mem_req) req_seen++;
            if (mem_req && !mem_we && idx < n) early_rd++;
            if (cyc == 1) err_cyc1 = error;
            if (done) begin
                done_cyc    = cyc;
                err_at_done = error;
            end
            if (wr_valid && wr_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        mem_gnt = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] expw;
        int          bad;
        logic [AW-1:0] wrap_exp [4];
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        wr_valid = 1'b0; wr_data = '0; mem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h0);
        check("rst_checksum", checksum, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic job: checksum of 1,2,3,4 is 1 -> 0 -> 3 -> 2
        stream = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_job(15'h0010, 4, 1'b0, -1);
        check("t1_done_cyc", 32'(done_cyc), 32'd10);
        check("t1_checksum", checksum, 32'h2);
        check("t1_err_done", 32'(err_at_done), 32'h0);
        check("t1_ready_start", 32'(ready_at_start), 32'h0);
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_nwrites", 32'(waddr_log.size()), 32'd4);
        check("t1_nreads", 32'(raddr_log.size()), 32'd4);
        bad = 0;
        for (int i = 0; i < 4 && i < waddr_log.size() && i < raddr_log.size(); i++) begin
            if (waddr_log[i] !== AW'(16 + i) || wdata_log[i] !== 32'(i + 1) ||
                raddr_log[i] !== AW'(16 + i)) bad++;
        end
        check("t1_addr_data", 32'(bad), 32'd0);

        // Corrupted read at 0x12: read checksum 1 -> 0 -> 2 -> 0 differs from 2
        flip_en = 1'b1;
        run_job(15'h0010, 4, 1'b0, -1);
        flip_en = 1'b0;
        check("t2_done_cyc", 32'(done_cyc), 32'd10);
        check("t2_err_done", 32'(err_at_done), 32'h1);
        repeat (3) @(negedge clk);
        #1;
        check("t2_err_sticky", 32'(error), 32'h1);
        @(negedge clk);

        // Random grant and stream gaps
        stream.delete();
        expw = '0;
        for (int i = 0; i < 64; i++) begin
            stream.push_back($urandom);
            expw = csum(expw, stream[i]);
        end
        run_job(15'h0100, 64, 1'b1, -1);
        check("t3_err_cleared", 32'(err_cyc1), 32'h0);
        check("t3_done_seen", 32'(done_cyc > 0), 32'h1);
        check("t3_nwrites", 32'(waddr_log.size()), 32'd64);
        check("t3_nreads", 32'(raddr_log.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < 64 && i < waddr_log.size() && i < raddr_log.size(); i++) begin
            if (waddr_log[i] !== AW'(256 + i) || wdata_log[i] !== stream[i] ||
                raddr_log[i] !== AW'(256 + i)) bad++;
        end
        check("t3_order", 32'(bad), 32'd0);
        check("t3_early_read", 32'(early_rd), 32'd0);
        check("t3_checksum", checksum, expw);
        check("t3_error", 32'(error), 32'h0);

        // Address wrap: A,B,C,D -> 0xA, 0x1F, 0x32, 0x69
        stream = '{32'hA, 32'hB, 32'hC, 32'hD};
        wrap_exp = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
        run_job(15'h7FFE, 4, 1'b0, -1);
        check("t4_done_cyc", 32'(done_cyc), 32'd10);
        check("t4_checksum", checksum, 32'h69);
        check("t4_nwrites", 32'(waddr_log.size()), 32'd4);
        check("t4_nreads", 32'(raddr_log.size()), 32'd4);
        bad = 0;
        for (int i = 0; i < 4 && i < waddr_log.size() && i < raddr_log.size(); i++) begin
            if (waddr_log[i] !== wrap_exp[i] || raddr_log[i] !== wrap_exp[i]) bad++;
        end
        check("t4_wrap_addr", 32'(bad), 32'd0);
        check("t4_error", 32'(error), 32'h0);

        // Zero-length job
        stream.delete();
        run_job(15'h0055, 0, 1'b0, -1);
        check("t5_done_cyc", 32'(done_cyc), 32'd1);
        check("t5_req_seen", 32'(req_seen), 32'd0);
        check("t5_checksum", checksum, 32'h0);
        check("t5_error", 32'(error), 32'h0);

        // Reset during READ with three reads still to issue
        stream = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_job(15'h0040, 4, 1'b0, 6);
        check("t6_in_read", 32'({mem_req, mem_we}), 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rst_req", 32'(mem_req), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_error", 32'(error), 32'h0);
        check("t6_rst_checksum", checksum, 32'h0);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk);

        // Fresh job after reset: 5,9 -> 0x5 -> 0x3
        stream = '{32'h5, 32'h9};
        run_job(15'h0020, 2, 1'b0, -1);
        check("t6_done_cyc", 32'(done_cyc), 32'd6);
        check("t6_checksum", checksum, 32'h3);
        check("t6_error", 32'(error), 32'h0);
        check("t6_nreads", 32'(raddr_log.size()), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
